// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, dmem commands, FSM states.
// Also holds the alignment check used when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_t;

    // An illegal size is reported the same way as a misaligned address.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr_lo[0];
            SIZE_WORD: err = (addr_lo != 2'b00);
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the core's right-aligned data and the 32-bit dmem word.
// Stores: lane mask and replicated write data. Loads: lane extraction and extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_raw,
    output logic [3:0]        w_en,
    output logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] shifted;
    logic              sign_fill;

    assign shifted = rdata_raw >> {addr_lo, 3'b000};

    always_comb begin
        w_en      = 4'b0000;
        din       = '0;
        rdata     = '0;
        sign_fill = 1'b0;
        case (size)
            SIZE_BYTE: begin
                w_en      = 4'b0001 << addr_lo;
                din       = {4{wdata[7:0]}};
                sign_fill = ~is_unsigned & shifted[7];
                rdata     = {{24{sign_fill}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                w_en      = 4'b0011 << {addr_lo[1], 1'b0};
                din       = {2{wdata[15:0]}};
                sign_fill = ~is_unsigned & shifted[15];
                rdata     = {{16{sign_fill}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                w_en  = 4'b1111;
                din   = wdata;
                rdata = shifted;
            end
            default: begin
                w_en  = 4'b0000;
                din   = '0;
                rdata = '0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core request port and a one-cycle dmem.
//
// state    | meaning
// ST_IDLE  | req_ready=1, waiting for a request
// ST_ISSUE | one-cycle dmem command (read or write)
// ST_WAIT  | load only: dout valid, captured into resp_rdata
// ST_RESP  | one-cycle resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [1:0]        en,
    output logic [3:0]        w_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    lsu_state_t state, state_next;

    logic              accept;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [3:0]        lane_w_en;
    logic [DATA_W-1:0] lane_din;
    logic [DATA_W-1:0] lane_rdata;

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size        (r_size),
        .addr_lo     (r_addr[1:0]),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .rdata_raw   (dout),
        .w_en        (lane_w_en),
        .din         (lane_din),
        .rdata       (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        en         = MEM_IDLE;
        w_en       = 4'b0000;
        addr       = '0;
        din        = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = access_err(req_size, req_addr[1:0]) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                addr = {r_addr[ADDR_W-1:2], 2'b00};
                if (r_we) begin
                    en         = MEM_WR;
                    w_en       = lane_w_en;
                    din        = lane_din;
                    state_next = ST_RESP;
                end else begin
                    en         = MEM_RD;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Response data is cleared on accept so stores and errors report zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                rdata_q    <= '0;
                err_q      <= access_err(req_size, req_addr[1:0]);
            end
            if (state == ST_WAIT) begin
                rdata_q <= lane_rdata;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors, a tiny dmem read model,
// latency/issue observation per request, reset abort and back-to-back acceptance.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  en;
    logic [3:0]  w_en;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .en           (en),
        .w_en         (w_en),
        .addr         (addr),
        .din          (din),
        .dout         (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request from accept to response. exp_en = 0 means no dmem access expected.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] memw, input logic [1:0] exp_en,
                           input logic [31:0] exp_addr, input logic [3:0] exp_wen,
                           input logic [31:0] exp_din, input int exp_lat,
                           input logic [31:0] exp_rdata, input logic exp_err);
        int          issue_cnt = 0;
        int          junk = 0;
        int          lat = 0;
        logic        got = 1'b0;
        logic        rd_pending = 1'b0;
        logic [1:0]  s_en = 2'b00;
        logic [31:0] s_addr = '0;
        logic [3:0]  s_wen = '0;
        logic [31:0] s_din = '0;
        logic [31:0] s_rdata = '0;
        logic        s_err = 1'b0;

        dout = 32'hDEADBEEF;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        check({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
        for (int c = 1; c <= 6 && !got; c++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (rd_pending) begin
                dout       = memw;
                rd_pending = 1'b0;
            end
            @(negedge clk);
            if (en != 2'b00) begin
                issue_cnt++;
                s_en   = en;
                s_addr = addr;
                s_wen  = w_en;
                s_din  = din;
                if (en == 2'b01) rd_pending = 1'b1;
            end else if (w_en != 4'b0 || addr != 32'b0 || din != 32'b0) begin
                junk++;
            end
            if (resp_valid) begin
                got     = 1'b1;
                lat     = c;
                s_rdata = resp_rdata;
                s_err   = resp_err;
            end
        end
        check({tag, ":issue_cycles"}, issue_cnt, (exp_en != 2'b00) ? 32'd1 : 32'd0);
        if (exp_en != 2'b00) begin
            check({tag, ":en"}, {30'b0, s_en}, {30'b0, exp_en});
            check({tag, ":addr"}, s_addr, exp_addr);
            check({tag, ":w_en"}, {28'b0, s_wen}, {28'b0, exp_wen});
            if (exp_en == 2'b10) check({tag, ":din"}, s_din, exp_din);
        end
        check({tag, ":idle_outputs_zero"}, junk, 32'd0);
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":rdata"}, s_rdata, exp_rdata);
        check({tag, ":err"}, {31'b0, s_err}, {31'b0, exp_err});
        @(negedge clk);
        check({tag, ":resp_pulse_end"}, {30'b0, resp_valid, req_ready}, 32'd1);
        dout = 32'hDEADBEEF;
    endtask

    initial begin
        int   accepts;
        int   resps;
        int   issues;
        int   stray;
        logic [5:0] ready_seq;

        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        dout         = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset:en", {30'b0, en}, 32'd0);
        check("reset:w_en", {28'b0, w_en}, 32'd0);
        check("reset:addr", addr, 32'd0);
        check("reset:din", din, 32'd0);
        check("reset:resp", {30'b0, resp_valid, resp_err}, 32'd0);
        check("reset:rdata", resp_rdata, 32'd0);
        check("reset:ready", {31'b0, req_ready}, 32'd1);

        //       tag          we    size   uns   addr          wdata         mem           en     addr          w_en     din           lat rdata         err
        run_req("st_half",   1'b1, 2'b01, 1'b0, 32'h80000002, 32'h20221118, 32'h0,        2'b10, 32'h80000000, 4'b1100, 32'h11181118, 2, 32'h0,        1'b0);
        run_req("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h00100002, 32'h0,        32'h11987251, 2'b01, 32'h00100000, 4'b0000, 32'h0,        3, 32'hFFFFFF98, 1'b0);
        run_req("ld_byte_u", 1'b0, 2'b00, 1'b1, 32'h00100002, 32'h0,        32'h11987251, 2'b01, 32'h00100000, 4'b0000, 32'h0,        3, 32'h00000098, 1'b0);
        run_req("ld_word",   1'b0, 2'b10, 1'b0, 32'h00100004, 32'h0,        32'h18790475, 2'b01, 32'h00100004, 4'b0000, 32'h0,        3, 32'h18790475, 1'b0);
        run_req("ld_w_mis",  1'b0, 2'b10, 1'b0, 32'h80000001, 32'h0,        32'h0,        2'b00, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        1'b1);
        run_req("ld_ill_sz", 1'b0, 2'b11, 1'b0, 32'h00000010, 32'h0,        32'h0,        2'b00, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        1'b1);
        run_req("st_byte3",  1'b1, 2'b00, 1'b0, 32'h00000203, 32'h000000A5, 32'h0,        2'b10, 32'h00000200, 4'b1000, 32'hA5A5A5A5, 2, 32'h0,        1'b0);
        run_req("st_word",   1'b1, 2'b10, 1'b0, 32'h00000010, 32'hCAFEF00D, 32'h0,        2'b10, 32'h00000010, 4'b1111, 32'hCAFEF00D, 2, 32'h0,        1'b0);
        run_req("ld_half_s", 1'b0, 2'b01, 1'b0, 32'h00000022, 32'h0,        32'h80010000, 2'b01, 32'h00000020, 4'b0000, 32'h0,        3, 32'hFFFF8001, 1'b0);
        run_req("ld_half_u", 1'b0, 2'b01, 1'b1, 32'h00000020, 32'h0,        32'h1234F00D, 2'b01, 32'h00000020, 4'b0000, 32'h0,        3, 32'h0000F00D, 1'b0);
        run_req("st_h_mis",  1'b1, 2'b01, 1'b0, 32'h00000041, 32'h00001234, 32'h0,        2'b00, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        1'b1);

        // Reset asserted while a load sits in WAIT.
        @(negedge clk);
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h00000100;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_wait:issue_en", {30'b0, en}, 32'd1);
        @(posedge clk);
        #1 dout = 32'h55667788;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_wait:en", {30'b0, en}, 32'd0);
        check("rst_wait:ready", {31'b0, req_ready}, 32'd1);
        check("rst_wait:resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_wait:rdata", resp_rdata, 32'd0);
        rst  = 1'b1;
        dout = 32'hDEADBEEF;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid || en != 2'b00) stray++;
        end
        check("rst_wait:no_late_resp", stray, 32'd0);

        // Back-to-back: req_valid held high across two store transactions.
        @(negedge clk);
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h00000300;
        req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        accepts   = 0;
        resps     = 0;
        issues    = 0;
        ready_seq = '0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            ready_seq[c] = req_ready;
            if (req_ready) accepts++;
            if (resp_valid) resps++;
            if (en == 2'b10) issues++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b:ready_seq", {26'b0, ready_seq}, 32'b001001);
        check("b2b:accepts", accepts, 32'd2);
        check("b2b:issues", issues, 32'd2);
        check("b2b:resps", resps, 32'd2);
        repeat (4) @(negedge clk);
        check("b2b:idle_after", {30'b0, req_ready, resp_valid}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
